csa_resolver: RTL and testbench

- Consumes a carry-save pair (partial sum + pre-shifted carry vector) from the multiplier compression tree and resolves it into a single binary result.
- Uses a sequential carry-propagate adder that processes CW bits per cycle, trading latency for a short critical path.
- Sits between the compression stage and the multiplier result register, with a valid/ready handshake on both sides.

---
 rtl/csa_pkg.sv | 27 ++
 rtl/csa_chunk_add.sv | 21 ++
 rtl/csa_resolver.sv | 158 +++++++++++++++
 tb/tb_csa_resolver.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver.
//   - state_t       : resolver FSM states
//   - csa_nchunk()  : number of CW-bit chunks in a DW-bit operand
//   - csa_width_ok(): true when DW splits into whole CW-bit chunks
//   - CSA_CFG_OK    : width check applied to the default DW/CW
package csa_pkg;

    localparam int unsigned CSA_DW = 16;
    localparam int unsigned CSA_CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned csa_nchunk(input int unsigned dw, input int unsigned cw);
        return dw / cw;
    endfunction

    function automatic bit csa_width_ok(input int unsigned dw, input int unsigned cw);
        return (cw != 0) && (dw >= cw) && ((dw % cw) == 0);
    endfunction

    localparam bit CSA_CFG_OK = csa_width_ok(CSA_DW, CSA_CW);

endpackage

// File: rtl/csa_chunk_add.sv
// Combinational CW-bit adder with carry in/out; one chunk of the resolver.
// Ports:
//   a, b    : CW-bit chunk operands
//   cin     : carry from the previous chunk
//   sum_c   : CW-bit chunk sum
//   cout_c  : carry out of the chunk MSB
module csa_chunk_add #(
    parameter int unsigned CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum_c,
    output logic          cout_c
);

    localparam int unsigned SW = CW + 1;

    assign {cout_c, sum_c} = SW'(a) + SW'(b) + SW'(cin);

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair (sum_i + carry_i) into one binary result using
// a sequential carry-propagate adder that handles CW bits per cycle.
// Optional feature macro: CSA_RESOLVER_EARLY_EXIT_EN -- finish as soon as the
// remaining operand bits are zero and no carry is pending.
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o : operand handshake (ready only in IDLE)
//   sum_i, carry_i        : partial sum and pre-shifted carry vectors
//   out_valid_o/out_ready_i : result handshake (valid only in DONE)
//   result_o              : (sum_i + carry_i) mod 2^DW
//   cout_o                : carry out of bit DW-1
module csa_resolver
    import csa_pkg::*;
#(
    parameter int unsigned DW = CSA_DW,
    parameter int unsigned CW = CSA_CW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] sum_i,
    input  logic [DW-1:0] carry_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] result_o,
    output logic          cout_o
);

    localparam int unsigned NCHUNK = csa_nchunk(DW, CW);
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned IDX_W  = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);
    localparam bit CFG_OK = CSA_CFG_OK && csa_width_ok(DW, CW);

    state_t           state, state_d;
    logic [DW-1:0]    op_sum, op_sum_d;
    logic [DW-1:0]    op_carry, op_carry_d;
    logic [DW-1:0]    result_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             cin, cin_d;
    logic             cout_d;
    logic             in_ready_d;
    logic             out_valid_d;

    logic [IDX_W-1:0] base;
    logic [CW-1:0]    chunk_sum;
    logic             chunk_cout;

    // Bit offset of the chunk being resolved this cycle.
    assign base = IDX_W'(cnt) * IDX_W'(CW);

    csa_chunk_add #(
        .CW (CW)
    ) u_chunk_add (
        .a      (op_sum[base +: CW]),
        .b      (op_carry[base +: CW]),
        .cin    (cin),
        .sum_c  (chunk_sum),
        .cout_c (chunk_cout)
    );

`ifdef CSA_RESOLVER_EARLY_EXIT_EN
    logic upper_zero;

    // No operand bit above the current chunk is set in either vector.
    assign upper_zero = ((op_sum | op_carry) >> (32'(base) + CW)) == '0;
`endif

    // A ragged final chunk is not supported.
    always_ff @(posedge clk_i) begin
        assert (CFG_OK) else $error("csa_resolver: DW must be a whole multiple of CW");
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            op_sum      <= '0;
            op_carry    <= '0;
            result_o    <= '0;
            cnt         <= '0;
            cin         <= 1'b0;
            cout_o      <= 1'b0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
        end else begin
            state       <= state_d;
            op_sum      <= op_sum_d;
            op_carry    <= op_carry_d;
            result_o    <= result_d;
            cnt         <= cnt_d;
            cin         <= cin_d;
            cout_o      <= cout_d;
            in_ready_o  <= in_ready_d;
            out_valid_o <= out_valid_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        op_sum_d    = op_sum;
        op_carry_d  = op_carry;
        result_d    = result_o;
        cnt_d       = cnt;
        cin_d       = cin;
        cout_d      = cout_o;
        in_ready_d  = in_ready_o;
        out_valid_d = out_valid_o;

        unique case (state)
            IDLE: begin
                if (in_valid_i) begin
                    op_sum_d   = sum_i;
                    op_carry_d = carry_i;
                    result_d   = '0;
                    cout_d     = 1'b0;
                    cnt_d      = '0;
                    cin_d      = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                result_d[base +: CW] = chunk_sum;
                cin_d                = chunk_cout;
                cnt_d                = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    cout_d      = chunk_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
`ifdef CSA_RESOLVER_EARLY_EXIT_EN
                else if (!chunk_cout && upper_zero) begin
                    // Upper result chunks are already zero from the accept.
                    cout_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver (DW=16, CW=4): the driver pushes the
// expected sum, carry-out and latency at each accepted handshake; a monitor
// pops and compares whenever a result is handed over.
module tb_csa_resolver;

    localparam int DW     = 16;
    localparam int CW     = 4;
    localparam int NCHUNK = DW / CW;

    logic          clk_i;
    logic          rst_ni;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] sum_i;
    logic [DW-1:0] carry_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] result_o;
    logic          cout_o;

    typedef struct {
        logic [DW-1:0] res;
        logic          cout;
        int            lat;
        int            acc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rdy_mode = 1;   // 0: random, 1: always ready, 2: stalled
    bit            in_done = 0;
    bit            stalled = 0;
    logic [DW-1:0] held_res;
    logic          held_cout;

    csa_resolver #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sum_i       (sum_i),
        .carry_i     (carry_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .cout_o      (cout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Cycles from accept to out_valid: the first chunk whose carry-out is 0
    // with nothing left above it ends the add early when the feature is built.
    function automatic int exp_latency(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int          ee;
        bit          found;
        int unsigned w;
        int unsigned mask;
        int unsigned lo;
        ee    = NCHUNK;
        found = 1'b0;
        for (int k = 0; k < NCHUNK - 1; k++) begin
            w    = 32'(CW * (k + 1));
            mask = (32'd1 << w) - 32'd1;
            lo   = (32'(a) & mask) + (32'(b) & mask);
            if (!found && ((lo >> w) & 32'd1) == 32'd0 && ((32'(a) | 32'(b)) >> w) == 32'd0) begin
                ee    = k + 1;
                found = 1'b1;
            end
        end
`ifdef CSA_RESOLVER_EARLY_EXIT_EN
        return ee;
`else
        return (ee > 0) ? NCHUNK : NCHUNK;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        int   guard;
        guard = 0;
        while (!in_ready_o || !rst_ni) begin
            in_valid_i = 1'($urandom_range(0, 1));
            sum_i      = DW'($urandom);
            carry_i    = DW'($urandom);
            @(negedge clk_i);
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready_o got %b, expected 1 within 200 cycles", in_ready_o);
                return;
            end
        end
        in_valid_i    = 1'b1;
        sum_i         = a;
        carry_i       = b;
        {e.cout, e.res} = 17'(a) + 17'(b);
        e.lat         = exp_latency(a, b);
        e.acc         = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk_i);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk_i);
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: latency on first valid, hold while stalled, compare on handover.
    initial begin
        out_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                in_done     = 1'b0;
                stalled     = 1'b0;
                out_ready_i = 1'b0;
            end else begin
                if (out_valid_o && !in_done) begin
                    in_done = 1'b1;
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: result %h cout %b with empty scoreboard", result_o, cout_o);
                    end else begin
                        chk("latency", 32'(cyc), 32'(exp_q[0].acc + exp_q[0].lat));
                    end
                end else if (out_valid_o && stalled) begin
                    chk("hold_result", 32'(result_o), 32'(held_res));
                    chk("hold_cout", 32'(cout_o), 32'(held_cout));
                    chk("hold_in_ready", 32'(in_ready_o), 32'd0);
                end
                case (rdy_mode)
                    0:       out_ready_i = ($urandom_range(0, 3) != 0);
                    1:       out_ready_i = 1'b1;
                    default: out_ready_i = 1'b0;
                endcase
                if (out_valid_o && in_done) begin
                    if (out_ready_i) begin
                        if (exp_q.size() != 0) begin
                            mon_e = exp_q.pop_front();
                            chk("result", 32'(result_o), 32'(mon_e.res));
                            chk("cout", 32'(cout_o), 32'(mon_e.cout));
                        end
                        in_done = 1'b0;
                        stalled = 1'b0;
                    end else begin
                        stalled   = 1'b1;
                        held_res  = result_o;
                        held_cout = cout_o;
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        logic [DW-1:0] a;
        logic [DW-1:0] b;

        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        sum_i      = '0;
        carry_i    = '0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        chk("reset_in_ready", 32'(in_ready_o), 32'd1);
        chk("reset_out_valid", 32'(out_valid_o), 32'd0);
        chk("reset_result", 32'(result_o), 32'd0);
        chk("reset_cout", 32'(cout_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed cases: basic, full propagation, early-exit candidates.
        rdy_mode = 1;
        send(16'h1234, 16'h0F0F); in_valid_i = 1'b0; drain();
        send(16'hFFFF, 16'h0001); in_valid_i = 1'b0; drain();
        send(16'hFFFF, 16'h0002); in_valid_i = 1'b0; drain();
        send(16'h0003, 16'h0004); in_valid_i = 1'b0; drain();
        send(16'h000F, 16'h0001); in_valid_i = 1'b0; drain();
        send(16'h0000, 16'h0000); in_valid_i = 1'b0; drain();
        send(16'h8000, 16'h8000); in_valid_i = 1'b0; drain();

        // Backpressure: result held for 5 stalled cycles, new input ignored.
        rdy_mode = 2;
        send(16'hFFFF, 16'h0002);
        in_valid_i = 1'b0;
        guard = 0;
        while (!out_valid_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        chk("bp_valid_seen", 32'(out_valid_o), 32'd1);
        repeat (5) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            sum_i      = DW'($urandom);
            carry_i    = DW'($urandom);
            chk("bp_out_valid", 32'(out_valid_o), 32'd1);
            chk("bp_in_ready", 32'(in_ready_o), 32'd0);
        end
        in_valid_i = 1'b0;
        rdy_mode   = 1;
        guard = 0;
        while (out_valid_o && guard < 10) begin
            @(negedge clk_i);
            guard++;
        end
        chk("bp_release_out_valid", 32'(out_valid_o), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready_o), 32'd1);
        drain();

        // Reset two cycles into an operation.
        send(16'h1234, 16'h0F0F);
        in_valid_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_result", 32'(result_o), 32'd0);
        chk("midrst_cout", 32'(cout_o), 32'd0);
        chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
        exp_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        chk("midrst_no_output", 32'(out_valid_o), 32'd0);
        rst_ni = 1'b1;
        send(16'h00FF, 16'h0001); in_valid_i = 1'b0; drain();

        // Random back-to-back pairs with random backpressure.
        rdy_mode = 0;
        for (int i = 0; i < 1000; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            case ($urandom_range(0, 3))
                0: begin a = a & 16'h00FF; b = b & 16'h000F; end
                1: begin a = 16'hFFFF; end
                default: ;
            endcase
            send(a, b);
        end
        in_valid_i = 1'b0;
        rdy_mode   = 1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
